// File: rtl/ranging_sequencer_if.sv
// Pin- and result-side signals of one ultrasonic ranging channel.
// The sequencer takes the slave side. The sensor model or the host logic takes the master side.
interface ranging_sequencer_if #(
    parameter int CW = 32
);
    logic          enable;
    logic          start;
    logic          echo;
    logic          trig;
    logic          busy;
    logic          meas_valid;
    logic [CW-1:0] meas_cycles;
    logic          meas_timeout;

    modport master (
        output enable, start, echo,
        input  trig, busy, meas_valid, meas_cycles, meas_timeout
    );

    modport slave (
        input  enable, start, echo,
        output trig, busy, meas_valid, meas_cycles, meas_timeout
    );
endinterface

// File: rtl/ranging_sequencer.sv
// One ultrasonic ranging cycle at a time: trig pulse, wait for echo rise,
// measure echo width, hold off. Runs continuously while enabled or once per start.
module ranging_sequencer #(
    parameter int TRIG_CYCLES  = 120,
    parameter int RISE_TIMEOUT = 36000,
    parameter int MAX_ECHO     = 456000,
    parameter int HOLDOFF      = 720000,
    parameter int CW           = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    ranging_sequencer_if.slave   rs
);

    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] RISE_LAST = CW'(RISE_TIMEOUT - 1);
    localparam logic [CW-1:0] ECHO_CAP  = CW'(MAX_ECHO);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_HOLDOFF
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          trig_q, trig_d;
    logic          busy_q, busy_d;
    logic          meas_valid_q, meas_valid_d;
    logic [CW-1:0] meas_cycles_q, meas_cycles_d;
    logic          meas_timeout_q, meas_timeout_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          sync3_q, sync3_d;

    // es is the synchronized echo. sync3 is its one-cycle-old copy for rise detection.
    logic es;
    logic es_rise;
    assign es      = sync2_q;
    assign es_rise = sync2_q & ~sync3_q;

    // Next-state and output decode. The shared counter restarts on every state entry.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + CW'(1);
        trig_d         = trig_q;
        busy_d         = busy_q;
        meas_valid_d   = 1'b0;
        meas_cycles_d  = meas_cycles_q;
        meas_timeout_d = meas_timeout_q;
        sync1_d        = rs.echo;
        sync2_d        = sync1_q;
        sync3_d        = sync2_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rs.enable || rs.start) begin
                    state_d = S_TRIG;
                    trig_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = S_WAIT_RISE;
                    trig_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_WAIT_RISE: begin
                // An echo that is already high on entry gives no rise, so it ends in the timeout branch.
                if (es_rise) begin
                    state_d = S_MEASURE;
                    cnt_d   = CW'(1);
                end else if (cnt_q == RISE_LAST) begin
                    state_d        = S_HOLDOFF;
                    cnt_d          = '0;
                    meas_valid_d   = 1'b1;
                    meas_cycles_d  = '0;
                    meas_timeout_d = 1'b1;
                end
            end
            S_MEASURE: begin
                if (!es) begin
                    state_d        = S_HOLDOFF;
                    cnt_d          = '0;
                    meas_valid_d   = 1'b1;
                    meas_cycles_d  = cnt_q;
                    meas_timeout_d = 1'b0;
                end else if (cnt_q == ECHO_CAP) begin
                    // Any echo still high after this is absorbed by the holdoff.
                    state_d        = S_HOLDOFF;
                    cnt_d          = '0;
                    meas_valid_d   = 1'b1;
                    meas_cycles_d  = ECHO_CAP;
                    meas_timeout_d = 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (rs.enable) begin
                        state_d = S_TRIG;
                        trig_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                trig_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter, synchronizer and registered outputs. Reset drops trig without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            trig_q         <= 1'b0;
            busy_q         <= 1'b0;
            meas_valid_q   <= 1'b0;
            meas_cycles_q  <= '0;
            meas_timeout_q <= 1'b0;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            sync3_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            trig_q         <= trig_d;
            busy_q         <= busy_d;
            meas_valid_q   <= meas_valid_d;
            meas_cycles_q  <= meas_cycles_d;
            meas_timeout_q <= meas_timeout_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            sync3_q        <= sync3_d;
        end
    end

    assign rs.trig         = trig_q;
    assign rs.busy         = busy_q;
    assign rs.meas_valid   = meas_valid_q;
    assign rs.meas_cycles  = meas_cycles_q;
    assign rs.meas_timeout = meas_timeout_q;

endmodule

// File: tb/tb_ranging_sequencer.sv
// Directed bench for ranging_sequencer with small timing parameters.
// Expected results are queued by the stimulus and popped by a monitor on every meas_valid.
module tb_ranging_sequencer;

    localparam int CW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;

    ranging_sequencer_if #(.CW(CW)) bus ();

    ranging_sequencer #(
        .TRIG_CYCLES (4),
        .RISE_TIMEOUT(20),
        .MAX_ECHO    (50),
        .HOLDOFF     (30),
        .CW          (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rs   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cycles;
        bit timeout;
    } exp_t;

    exp_t exp_q[$];
    int   rise_cyc[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   trig_rises = 0;
    int   mv_count = 0;
    logic trig_prev = 1'b0;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: counts trig rises and scores every meas_valid against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.trig === 1'b1 && trig_prev !== 1'b1) begin
                trig_rises++;
                rise_cyc.push_back(cyc);
            end
            trig_prev = bus.trig;
            if (bus.meas_valid === 1'b1) begin
                mv_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_meas_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("meas_cycles", int'(bus.meas_cycles), e.cycles);
                    check("meas_timeout", int'(bus.meas_timeout), int'(e.timeout));
                end
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #300000;
        $display("FAIL global_timeout: got time %0t, required finish earlier", $time);
        $fatal(1, "time limit");
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Returns at the first negedge with trig low. hi_len is the number of negedges trig was high.
    task automatic wait_trig_fall(output int hi_len);
        int n;
        n = 0;
        hi_len = 0;
        while (bus.trig !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("trig_rise_wait", 0, 1);
            return;
        end
        while (bus.trig === 1'b1 && hi_len < 200) begin
            hi_len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_mv(output int n);
        n = 0;
        while (bus.meas_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("meas_valid_wait", 0, 1);
    endtask

    // Counts negedges with busy high. When poke is set, start pulses are issued during the count.
    task automatic wait_idle(input bit poke, output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 300) begin
            if (poke) bus.start = (n == 5 || n == 15);
            n++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (n >= 300) check("busy_wait", 0, 1);
    endtask

    initial begin
        int hl, n, r0, base, mv0;
        int widths[3];
        widths[0] = 10;
        widths[1] = 25;
        widths[2] = 40;
        bus.enable = 1'b0;
        bus.start  = 1'b0;
        bus.echo   = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_trig", int'(bus.trig), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_meas_valid", int'(bus.meas_valid), 0);
        check("rst_meas_cycles", int'(bus.meas_cycles), 0);
        check("rst_meas_timeout", int'(bus.meas_timeout), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", int'(bus.busy), 0);

        // Single shot, 17-cycle echo
        r0 = trig_rises;
        exp_q.push_back('{17, 1'b0});
        pulse_start();
        wait_trig_fall(hl);
        check("t1_trig_len", hl, 4);
        repeat (5) @(negedge clk);
        bus.echo = 1'b1;
        repeat (17) @(negedge clk);
        bus.echo = 1'b0;
        wait_mv(n);
        check("t1_fall_to_valid", n, 3);
        wait_idle(1'b0, n);
        check("t1_holdoff_busy", n, 30);
        repeat (10) @(negedge clk);
        check("t1_trig_count", trig_rises - r0, 1);
        check("t1_idle_busy", int'(bus.busy), 0);

        // No echo
        r0 = trig_rises;
        exp_q.push_back('{0, 1'b1});
        pulse_start();
        wait_trig_fall(hl);
        check("t2_trig_len", hl, 4);
        wait_mv(n);
        check("t2_fall_to_valid", n, 20);
        wait_idle(1'b0, n);
        check("t2_holdoff_busy", n, 30);
        repeat (5) @(negedge clk);
        check("t2_trig_count", trig_rises - r0, 1);

        // Long echo, capped at 50
        r0 = trig_rises;
        exp_q.push_back('{50, 1'b1});
        pulse_start();
        wait_trig_fall(hl);
        repeat (5) @(negedge clk);
        bus.echo = 1'b1;
        repeat (80) @(negedge clk);
        bus.echo = 1'b0;
        wait_idle(1'b0, n);
        repeat (10) @(negedge clk);
        check("t3_trig_count", trig_rises - r0, 1);
        check("t3_idle_busy", int'(bus.busy), 0);

        // Continuous mode, enable dropped during the third measurement
        r0 = trig_rises;
        base = rise_cyc.size();
        for (int i = 0; i < 3; i++) exp_q.push_back('{widths[i], 1'b0});
        bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_trig_fall(hl);
            check("t4_trig_len", hl, 4);
            repeat (5) @(negedge clk);
            bus.echo = 1'b1;
            if (i == 2) begin
                repeat (10) @(negedge clk);
                bus.enable = 1'b0;
                repeat (widths[i] - 10) @(negedge clk);
            end else begin
                repeat (widths[i]) @(negedge clk);
            end
            bus.echo = 1'b0;
        end
        wait_mv(n);
        wait_idle(1'b0, n);
        check("t4_last_holdoff_busy", n, 30);
        repeat (60) @(negedge clk);
        check("t4_trig_count", trig_rises - r0, 3);
        check("t4_idle_busy", int'(bus.busy), 0);
        if (rise_cyc.size() >= base + 3) begin
            // Period = 4 trig + 8 wait-rise + width + 30 holdoff.
            check("t4_period_1", rise_cyc[base + 1] - rise_cyc[base], 52);
            check("t4_period_2", rise_cyc[base + 2] - rise_cyc[base + 1], 67);
        end else begin
            check("t4_rises_recorded", rise_cyc.size() - base, 3);
        end

        // Reset while trig is high
        r0 = trig_rises;
        mv0 = mv_count;
        pulse_start();
        n = 0;
        while (bus.trig !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t5_trig_high", int'(bus.trig), 1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_trig_async_drop", int'(bus.trig), 0);
        check("t5_busy", int'(bus.busy), 0);
        check("t5_meas_valid", int'(bus.meas_valid), 0);
        check("t5_meas_cycles", int'(bus.meas_cycles), 0);
        check("t5_meas_timeout", int'(bus.meas_timeout), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("t5_no_result", mv_count - mv0, 0);
        check("t5_idle_busy", int'(bus.busy), 0);
        check("t5_trig_count", trig_rises - r0, 1);

        // Stuck-high echo, start pulses during holdoff ignored
        bus.echo = 1'b1;
        repeat (5) @(negedge clk);
        r0 = trig_rises;
        exp_q.push_back('{0, 1'b1});
        pulse_start();
        wait_trig_fall(hl);
        check("t6_trig_len", hl, 4);
        wait_mv(n);
        check("t6_fall_to_valid", n, 20);
        wait_idle(1'b1, n);
        check("t6_holdoff_busy", n, 30);
        repeat (20) @(negedge clk);
        check("t6_trig_count", trig_rises - r0, 1);
        check("t6_idle_busy", int'(bus.busy), 0);
        bus.echo = 1'b0;

        repeat (5) @(negedge clk);
        check("scoreboard_left", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ranging_sequencer.md
Name: ranging_sequencer

Overview:
- Sequences one ultrasonic ranging cycle at a time: trigger pulse, wait for echo, measure echo width, hold off before the next cycle.
- Runs continuously while enabled, or single-shot on request.
- Sits between the echo/trig pins and the reading/history logic; the downstream logic consumes one meas_valid pulse plus value per cycle.
- Clock is 12 MHz from the on-chip oscillator (HF divider 0b10); defaults are in 12 MHz cycles.

Parameters:
- TRIG_CYCLES, 120: trig high time (10 us).
- RISE_TIMEOUT, 36000: maximum wait for the echo rising edge after trig falls (3 ms).
- MAX_ECHO, 456000: echo width cap (38 ms, no-object limit).
- HOLDOFF, 720000: quiet time after each cycle before the next trig (60 ms).
- CW, 32: width of the counter and of meas_cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  continuous ranging while high.
- start  in  1  single-cycle request for one measurement; honoured only in IDLE.
- echo  in  1  raw sensor echo, asynchronous to clk.
- trig  out  1  sensor trigger.
- busy  out  1  high in every state except IDLE.
- meas_valid  out  1  one-cycle pulse when a result is posted.
- meas_cycles  out  CW  last echo width in clk cycles; held between results.
- meas_timeout  out  1  qualifies the last result: 1 = no echo or echo capped; held with meas_cycles.

Behaviour:
- Reset (asynchronous, active-high) forces: state IDLE; trig, busy, meas_valid, meas_timeout = 0; meas_cycles = 0; counter = 0; synchronizer flops = 0.
- Reset mid-cycle drops trig immediately (asynchronously). No result is posted for the aborted cycle.
- Echo path: 2-flop synchronizer, then a 3rd flop for edge detection. All echo decisions use the synchronized value (es) and the rising edge (es_rise = es & ~es_d).
- One shared counter cnt (CW bits); it is cleared on every state entry.
- IDLE: leave when enable=1 or start=1, going to TRIG next cycle.
- TRIG: trig=1 for exactly TRIG_CYCLES clocks, then go to WAIT_RISE.
- WAIT_RISE:
  - On es_rise, go to MEASURE; cnt=1 on entry (the rise cycle counts).
  - If cnt reaches RISE_TIMEOUT-1 without a rise, post timeout (meas_cycles=0, meas_timeout=1) and go to HOLDOFF.
  - If echo is already high on entry (stuck high), there is no rise; this ends in the timeout path.
- MEASURE:
  - cnt increments each cycle while es=1.
  - On es=0, post meas_cycles=cnt, meas_timeout=0, then go to HOLDOFF.
  - If cnt reaches MAX_ECHO while es=1, post meas_cycles=MAX_ECHO, meas_timeout=1, then go to HOLDOFF. The remaining echo high time is absorbed by HOLDOFF.
- Posting: meas_cycles, meas_timeout and meas_valid are all registered in the same cycle as the transition to HOLDOFF. meas_valid is high for exactly that one cycle.
- HOLDOFF:
  - Lasts HOLDOFF clocks with trig=0.
  - On exit, go to TRIG if enable=1, else go to IDLE.
  - start is ignored outside IDLE; no queuing.
- enable falling mid-cycle: the current cycle completes, including its result and HOLDOFF, then the block returns to IDLE.
- start and enable high together in IDLE: one cycle starts; continuous mode follows while enable stays high.
- Measured latency: echo fall at the pin to meas_valid = 3 clk (synchronizer + register).
- Counter arithmetic: unsigned, saturating is not needed because compares stop it at its caps. Parameters must satisfy MAX_ECHO < 2^CW.

Test Plan (sim params: TRIG_CYCLES=4, RISE_TIMEOUT=20, MAX_ECHO=50, HOLDOFF=30):
- Single shot:
  - Stimulus: start pulse in IDLE; echo rises 5 clk after trig falls, stays high 17 clk.
  - Required: trig high exactly 4 clk; meas_valid one pulse with meas_cycles=17, meas_timeout=0; busy=1 until HOLDOFF ends (30 clk), then IDLE.
- No echo:
  - Stimulus: start pulse; echo held 0.
  - Required: meas_valid 20 clk after trig falls, with meas_cycles=0, meas_timeout=1; then HOLDOFF; then IDLE.
- Long echo:
  - Stimulus: echo high 80 clk.
  - Required: meas_cycles=50, meas_timeout=1, posted at count 50; no second trig until echo is low and HOLDOFF has elapsed.
- Continuous mode:
  - Stimulus: enable=1 with echo widths 10, 25, 40; enable dropped during the 3rd MEASURE.
  - Required: three meas_valid pulses carrying 10, 25, 40; the trig-to-trig period equals the full cycle length; after the 3rd HOLDOFF the block is in IDLE with no 4th trig.
- Reset mid-TRIG:
  - Stimulus: assert reset while trig=1.
  - Required: trig drops without waiting for a clk edge; all outputs return to reset values; no meas_valid is posted; after release the block is in IDLE.
- Stuck-high echo:
  - Stimulus: echo=1 before start, held throughout.
  - Required: timeout result (meas_cycles=0, meas_timeout=1); start pulses issued during HOLDOFF are ignored.
